// File: rtl/laplacian_pkg.sv
// Shared widths, FSM state type and the result clamp for the Laplacian sum collector.
package laplacian_pkg;
    localparam int SUM_W = 9;
    localparam int PIX_W = 8;
    localparam int ACC_W = 12;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [PIX_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
        if (a < 0)
            return '0;
        else if (a > 255)
            return '1;
        else
            return a[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with async reset; a push on full is accepted when a pop lands in the same cycle.
module pixel_fifo
    import laplacian_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/laplacian_sum_collector.sv
// Groups adder sums into pixels, computes 4*centre - sum(sums), clamps to 8 bits and queues the result.
module laplacian_sum_collector
    import laplacian_pkg::*;
#(
    parameter int SUMS_PER_PIXEL = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_done,
    input  logic [PIX_W-1:0] center_in,
    output logic [PIX_W-1:0] pixel_out,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic             stall,
    output logic             overflow,
    output logic [15:0]      pixel_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int K_W = 4;

    state_t                  state;
    logic signed [ACC_W-1:0] acc, acc_base, acc_next;
    logic [K_W-1:0]          k, k_next;
    logic                    complete, pop, wr_ok;
    logic [AW:0]             occ;
    logic                    full, empty;

    // Centre is only sampled on the first sum; later sums keep subtracting from the held acc.
    assign acc_base = (state == IDLE) ? {2'b00, center_in, 2'b00} : acc;
    assign acc_next = acc_base - {3'b000, sum_in};
    assign k_next   = (state == IDLE) ? K_W'(1) : k + 1'b1;
    assign complete = sum_done && (k_next == K_W'(SUMS_PER_PIXEL));
    assign pop      = pixel_ready && !empty;
    assign wr_ok    = complete && (!full || pop);

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (complete),
        .pop   (pop),
        .wdata (clamp(acc_next)),
        .rdata (pixel_out),
        .count (occ),
        .full  (full),
        .empty (empty)
    );

    assign pixel_valid = !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            k           <= '0;
            stall       <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
        end else begin
            if (sum_done) begin
                acc <= acc_next;
                if (complete) begin
                    state <= IDLE;
                    k     <= '0;
                end else begin
                    state <= ACCUM;
                    k     <= k_next;
                end
            end
            if (wr_ok)                pixel_count <= pixel_count + 1'b1;
            if (complete && !wr_ok)   overflow    <= 1'b1;
            // Lags occupancy by one edge; the DEPTH-1 threshold covers an in-flight completion.
            stall <= (occ >= (AW+1)'(FIFO_DEPTH - 1));
        end
    end
endmodule

// File: tb/tb_laplacian_sum_collector.sv
// Directed-vector bench for laplacian_sum_collector at default parameters.
module tb_laplacian_sum_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  sum_in;
    logic        sum_done;
    logic [7:0]  center_in;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        stall;
    logic        overflow;
    logic [15:0] pixel_count;

    int vectors = 0;
    int miscompares = 0;

    laplacian_sum_collector dut (
        .clk         (clk),
        .reset       (reset),
        .sum_in      (sum_in),
        .sum_done    (sum_done),
        .center_in   (center_in),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .stall       (stall),
        .overflow    (overflow),
        .pixel_count (pixel_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, leave time 1 after the edge for checks.
    task automatic step(input logic sd, input int s, input int c, input logic rdy);
        sum_done    = sd;
        sum_in      = 9'(s);
        center_in   = 8'(c);
        pixel_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},   32'(pixel_out), 0);
        chk({tag, "_valid"}, 32'(pixel_valid), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_ovf"},   32'(overflow), 0);
        chk({tag, "_cnt"},   32'(pixel_count), 0);
    endtask

    initial begin
        reset = 1'b1; sum_done = 0; sum_in = 0; center_in = 0; pixel_ready = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Basic pixel: 400 - 150 - 200 = 50
        step(1, 150, 100, 1);
        chk("basic_no_early", 32'(pixel_valid), 0);
        step(1, 200, 100, 1);
        chk("basic_valid", 32'(pixel_valid), 1);
        chk("basic_out",   32'(pixel_out), 50);
        chk("basic_cnt",   32'(pixel_count), 1);
        step(0, 0, 0, 1);
        chk("basic_popped", 32'(pixel_valid), 0);

        // Clamp low: 40 - 600 -> 0
        step(1, 300, 10, 1);
        step(1, 300, 10, 1);
        chk("clamp_lo_out", 32'(pixel_out), 0);
        chk("clamp_lo_valid", 32'(pixel_valid), 1);
        step(0, 0, 0, 1);
        // Clamp high: 1020 -> 255
        step(1, 0, 255, 1);
        step(1, 0, 255, 1);
        chk("clamp_hi_out", 32'(pixel_out), 255);
        chk("clamp_hi_cnt", 32'(pixel_count), 3);
        step(0, 0, 0, 1);

        // Gapped done: 240 - 40 - 20 = 180; centre on 2nd sum must be ignored
        step(1, 40, 60, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("gap_no_early", 32'(pixel_valid), 0);
        step(1, 20, 77, 1);
        chk("gap_out", 32'(pixel_out), 180);
        chk("gap_valid", 32'(pixel_valid), 1);
        step(0, 0, 0, 1);

        // Backpressure and overflow: 5 pixels of value 2, ready low
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(1, 1, 1, 0);
            if (p == 3) chk("bp_stall_after3", 32'(stall), 1);
            step(1, 1, 1, 0);
            if (p == 1) chk("bp_stall_after2", 32'(stall), 0);
        end
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_cnt", 32'(pixel_count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", 32'(pixel_valid), 1);
            chk("bp_drain_out",   32'(pixel_out), 2);
            step(0, 0, 0, 1);
        end
        chk("bp_drained", 32'(pixel_valid), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);

        // Full with simultaneous pop: fill 4,8,12,16 then push 20 while popping
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step(1, 0, c, 0);
            step(1, 0, c, 0);
        end
        step(1, 0, 5, 0);
        step(1, 0, 5, 1);
        chk("full_pop_ovf", 32'(overflow), 0);
        chk("full_pop_cnt", 32'(pixel_count), 5);
        chk("full_pop_stall", 32'(stall), 1);
        for (int i = 0; i < 4; i++) begin
            chk("full_pop_order", 32'(pixel_out), 32'(8 + 4 * i));
            step(0, 0, 0, 1);
        end
        chk("full_pop_empty", 32'(pixel_valid), 0);

        // Reset mid-pixel with two entries queued
        step(1, 0, 3, 0);
        step(1, 0, 3, 0);
        step(1, 0, 4, 0);
        step(1, 0, 4, 0);
        step(1, 150, 30, 0);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        #1 reset = 1'b0;
        step(1, 150, 100, 1);
        step(1, 200, 100, 1);
        chk("post_rst_out", 32'(pixel_out), 50);
        chk("post_rst_cnt", 32'(pixel_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
